// File: rtl/lab71_usb_rst_pkg.sv
// Shared constants and types for the USB controller reset sequencer.
// Holds the register map, CTRL/STATUS bit positions, FSM states, the
// default pulse/recovery lengths and a helper that clamps a length to >= 1.
package lab71_usb_rst_pkg;

   localparam int LEN_W = 24;

   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_PULSE   = 2'd2;
   localparam logic [1:0] ADDR_RECOVER = 2'd3;

   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_FORCE  = 2;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_USB  = 2;

   localparam logic [LEN_W-1:0] PULSE_DEFAULT_C   = 24'd50000;
   localparam logic [LEN_W-1:0] RECOVER_DEFAULT_C = 24'd500000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RECOVER = 2'd2
   } state_e;

   // A programmed length of 0 still yields a one-cycle phase.
   function automatic logic [LEN_W-1:0] len_min1(input logic [LEN_W-1:0] len);
      return (len == '0) ? LEN_W'(1) : len;
   endfunction

endpackage

// File: rtl/lab71_usb_rst_timer.sv
// 24-bit loadable down-counter used to time the reset and recovery phases.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   load_i        - load load_val_i this edge (takes priority over en_i)
//   load_val_i    - value to load
//   en_i          - count down this edge
//   expire_o      - high in the last counted cycle (count == 1 while enabled)
module lab71_usb_rst_timer
   import lab71_usb_rst_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [LEN_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             expire_o
);

   logic [LEN_W-1:0] cnt_q, cnt_d;

   // A load of N gives exactly N enabled cycles before the expiry edge.
   assign expire_o = en_i && (cnt_q == LEN_W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)                    cnt_d = load_val_i;
      else if (en_i && cnt_q != '0)  cnt_d = cnt_q - LEN_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/lab71_usb_rst_seq.sv
// Avalon-MM controlled reset sequencer for an external USB controller chip.
// A START write drives usb_rst_n low for PULSE_LEN cycles, then high for
// RECOVER_LEN cycles, then sets the sticky DONE flag. FORCE aborts to IDLE
// with usb_rst_n held low.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    - Avalon-MM slave write side
//   readdata              - combinational read data for address
//   usb_rst_n             - registered active-low reset to the USB chip
//   irq                   - level interrupt, DONE & IRQ_EN
module lab71_usb_rst_seq
   import lab71_usb_rst_pkg::*;
#(
   parameter logic [23:0] PULSE_DEFAULT   = PULSE_DEFAULT_C,
   parameter logic [23:0] RECOVER_DEFAULT = RECOVER_DEFAULT_C
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        usb_rst_n,
   output logic        irq
);

   state_e           state_q, state_d;
   logic             usb_rst_n_q, usb_rst_n_d;
   logic             done_q, done_d;
   logic             irq_en_q;
   logic [LEN_W-1:0] pulse_len_q, recover_len_q;

   logic             tmr_load, tmr_en, tmr_expire;
   logic [LEN_W-1:0] tmr_val;
   logic             done_set;

   logic wr_en, ctrl_wr, start_req, force_req, busy;
   logic unused_wdata;

   assign wr_en     = chipselect && !write_n;
   assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
   assign start_req = ctrl_wr && writedata[CTRL_START];
   assign force_req = ctrl_wr && writedata[CTRL_FORCE];
   assign busy      = (state_q != ST_IDLE);
   assign unused_wdata = ^writedata[31:LEN_W];

   lab71_usb_rst_timer u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .expire_o   (tmr_expire)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; FORCE overrides everything, START only counts in IDLE.
   always_comb begin
      state_d = state_q;
      if (force_req) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:    if (start_req)  state_d = ST_ASSERT;
            ST_ASSERT:  if (tmr_expire) state_d = ST_RECOVER;
            ST_RECOVER: if (tmr_expire) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
         endcase
      end
   end

   // Output / datapath control
   always_comb begin
      tmr_load    = 1'b0;
      tmr_val     = '0;
      tmr_en      = 1'b0;
      done_set    = 1'b0;
      usb_rst_n_d = usb_rst_n_q;
      if (force_req) begin
         tmr_load    = 1'b1;
         usb_rst_n_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: if (start_req) begin
               tmr_load    = 1'b1;
               tmr_val     = len_min1(pulse_len_q);
               usb_rst_n_d = 1'b0;
            end
            ST_ASSERT: begin
               tmr_en = 1'b1;
               if (tmr_expire) begin
                  tmr_load    = 1'b1;
                  tmr_val     = len_min1(recover_len_q);
                  usb_rst_n_d = 1'b1;
               end
            end
            ST_RECOVER: begin
               tmr_en   = 1'b1;
               done_set = tmr_expire;
            end
            default: ;
         endcase
      end
   end

   // DONE: set beats a same-cycle W1C; an accepted START clears it.
   always_comb begin
      done_d = done_q;
      if (done_set)
         done_d = 1'b1;
      else if ((wr_en && address == ADDR_STATUS && writedata[STAT_DONE]) ||
               (start_req && !force_req && !busy))
         done_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         usb_rst_n_q   <= 1'b0;
         done_q        <= 1'b0;
         irq_en_q      <= 1'b0;
         pulse_len_q   <= PULSE_DEFAULT;
         recover_len_q <= RECOVER_DEFAULT;
      end else begin
         usb_rst_n_q <= usb_rst_n_d;
         done_q      <= done_d;
         if (ctrl_wr) irq_en_q <= writedata[CTRL_IRQ_EN];
         // Lengths are frozen while a sequence runs.
         if (wr_en && !busy && address == ADDR_PULSE)   pulse_len_q   <= writedata[LEN_W-1:0];
         if (wr_en && !busy && address == ADDR_RECOVER) recover_len_q <= writedata[LEN_W-1:0];
      end
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         ADDR_CTRL:    readdata[CTRL_IRQ_EN] = irq_en_q;
         ADDR_STATUS:  readdata[2:0] = {usb_rst_n_q, done_q, busy};
         ADDR_PULSE:   readdata[LEN_W-1:0] = pulse_len_q;
         ADDR_RECOVER: readdata[LEN_W-1:0] = recover_len_q;
         default:      readdata = '0;
      endcase
   end

   assign usb_rst_n = usb_rst_n_q;
   assign irq       = done_q && irq_en_q;

endmodule

// File: tb/tb_lab71_usb_rst_seq.sv
module tb_lab71_usb_rst_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        usb_rst_n;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   lab71_usb_rst_seq dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .usb_rst_n  (usb_rst_n),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Advance to the next falling edge, release the bus and park on STATUS.
   task automatic tick();
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      address    = 2'd1;
      #1;
   endtask

   // Drive a write that the next rising edge samples.
   task automatic put(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
   endtask

   // Expected {irq, usb_rst_n, STATUS[2:0]} k cycles after the START edge.
   function automatic logic [31:0] seq_exp(input int p, input int r, input int k, input bit ie);
      int  pe, re;
      bit  usb, busy, done;
      pe   = (p == 0) ? 1 : p;
      re   = (r == 0) ? 1 : r;
      usb  = (k >= pe);
      busy = (k < pe + re);
      done = (k >= pe + re);
      return {27'd0, done & ie, usb, usb, done, busy};
   endfunction

   function automatic logic [31:0] obs();
      return {27'd0, irq, usb_rst_n, readdata[2:0]};
   endfunction

   task automatic test_reset();
      logic [31:0] got, exp;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd50000);
      exp_q.push_back(32'd500000);
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         #1;
         got = readdata;
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL reset_reg%0d got %0d expected %0d", a, got, exp);
         end
      end
      n_vec++;
      if (usb_rst_n !== 1'b0 || irq !== 1'b0) begin
         n_err++;
         $display("FAIL reset_pins got usb_rst_n=%b irq=%b expected 0 0", usb_rst_n, irq);
      end
   endtask

   // Program lengths, START, and follow the whole sequence.
   task automatic test_sequence(input string nm, input int p, input int r, input bit ie);
      logic [31:0] got, exp;
      tick(); put(2'd2, 32'(p));
      tick(); put(2'd3, 32'(r));
      tick(); put(2'd0, {29'd0, 1'b0, ie, 1'b1});
      for (int k = 0; k <= p + r + 2; k++) exp_q.push_back(seq_exp(p, r, k, ie));
      for (int k = 0; k <= p + r + 2; k++) begin
         tick();
         got = obs();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d got %b expected %b", nm, k, got[4:0], exp[4:0]);
         end
      end
   endtask

   task automatic test_irq_clear();
      logic [31:0] got, exp;
      test_sequence("irq_seq", 4, 3, 1'b1);
      put(2'd1, 32'h2);
      exp_q.push_back(32'b0_1_1_0_0);
      tick();
      got = obs();
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL irq_clear got %b expected %b", got[4:0], exp[4:0]);
      end
   endtask

   task automatic test_done_race();
      logic [31:0] got, exp;
      tick(); put(2'd2, 32'd1);
      tick(); put(2'd3, 32'd1);
      tick(); put(2'd0, 32'h1);
      for (int k = 0; k <= 3; k++) exp_q.push_back(seq_exp(1, 1, k, 1'b0));
      for (int k = 0; k <= 3; k++) begin
         tick();
         got = obs();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL done_race k=%0d got %b expected %b", k, got[4:0], exp[4:0]);
         end
         // W1C lands on the same edge that sets DONE
         if (k == 1) put(2'd1, 32'h2);
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] got, exp;
      tick(); put(2'd2, 32'd4);
      tick(); put(2'd3, 32'd3);
      tick(); put(2'd0, 32'h1);
      for (int k = 0; k <= 9; k++) exp_q.push_back(seq_exp(4, 3, k, 1'b0));
      for (int k = 0; k <= 9; k++) begin
         tick();
         got = obs();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL busy_ignore k=%0d got %b expected %b", k, got[4:0], exp[4:0]);
         end
         if (k == 4) put(2'd0, 32'h1);
         if (k == 5) put(2'd2, 32'd9);
      end
      exp_q.push_back(32'd4);
      address = 2'd2;
      #1;
      got = readdata;
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL pulse_len_locked got %0d expected %0d", got, exp);
      end
   endtask

   task automatic test_force();
      logic [31:0] got, exp;
      // FORCE from IDLE with DONE set: pin drops, DONE kept
      tick(); put(2'd0, 32'h4);
      exp_q.push_back(32'b0_0_0_1_0);
      tick();
      got = obs();
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL force_idle got %b expected %b", got[4:0], exp[4:0]);
      end
      // FORCE during the second ASSERT cycle
      put(2'd0, 32'h1);
      for (int k = 0; k <= 4; k++)
         exp_q.push_back((k < 2) ? 32'b0_0_0_0_1 : 32'b0_0_0_0_0);
      for (int k = 0; k <= 4; k++) begin
         tick();
         got = obs();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL force_assert k=%0d got %b expected %b", k, got[4:0], exp[4:0]);
         end
         if (k == 1) put(2'd0, 32'h4);
      end
      // START together with FORCE: nothing starts
      put(2'd0, 32'h5);
      for (int k = 0; k < 6; k++) exp_q.push_back(32'b0_0_0_0_0);
      for (int k = 0; k < 6; k++) begin
         tick();
         got = obs();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL start_force k=%0d got %b expected %b", k, got[4:0], exp[4:0]);
         end
      end
   endtask

   task automatic test_maxlen();
      logic [31:0] got, exp;
      tick(); put(2'd2, 32'hFFFF_FFFF);
      exp_q.push_back(32'h00FF_FFFF);
      tick();
      address = 2'd2;
      #1;
      got = readdata;
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL maxlen_readback got %h expected %h", got, exp);
      end
      put(2'd0, 32'h1);
      for (int k = 0; k < 5; k++) exp_q.push_back(32'b0_0_0_0_1);
      for (int k = 0; k < 5; k++) begin
         tick();
         got = obs();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL maxlen_run k=%0d got %b expected %b", k, got[4:0], exp[4:0]);
         end
      end
      put(2'd0, 32'h4);
      tick();
   endtask

   task automatic test_reset_mid();
      logic [31:0] got, exp;
      tick(); put(2'd2, 32'd4);
      tick(); put(2'd0, 32'h3);
      tick();
      tick();
      #2 reset_n = 1'b0;
      #1;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd50000);
      exp_q.push_back(32'd500000);
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         #1;
         got = readdata;
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL midreset_reg%0d got %0d expected %0d", a, got, exp);
         end
      end
      n_vec++;
      if (usb_rst_n !== 1'b0 || irq !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_pins got usb_rst_n=%b irq=%b expected 0 0", usb_rst_n, irq);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) exp_q.push_back(32'b0_0_0_0_0);
      for (int k = 0; k < 6; k++) begin
         tick();
         got = obs();
         exp = exp_q.pop_front();
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL post_reset k=%0d got %b expected %b", k, got[4:0], exp[4:0]);
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      test_reset();
      test_sequence("basic", 4, 3, 1'b0);
      test_irq_clear();
      test_done_race();
      test_busy_ignore();
      test_force();
      test_maxlen();
      test_sequence("zero_len", 0, 0, 1'b0);
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
